// File: rtl/bbpd_loop_ctrl_if.sv
// Loop-controller bundle: enable and votes toward the controller, phase code and lock status back.
// The optional hold input exists only when BBPD_CTRL_HOLD_EN is defined.
interface bbpd_loop_ctrl_if #(
  parameter int CODE_BITS = 8
);
  logic                 en;
  logic                 up;
  logic                 dn;
`ifdef BBPD_CTRL_HOLD_EN
  logic                 hold;
`endif
  logic [CODE_BITS-1:0] phase_code;
  logic                 code_valid;
  logic                 locked;
  logic [1:0]           state;

`ifdef BBPD_CTRL_HOLD_EN
  modport master (output en, up, dn, hold, input phase_code, code_valid, locked, state);
  modport slave  (input en, up, dn, hold, output phase_code, code_valid, locked, state);
`else
  modport master (output en, up, dn, input phase_code, code_valid, locked, state);
  modport slave  (input en, up, dn, output phase_code, code_valid, locked, state);
`endif
endinterface

// File: rtl/bbpd_loop_ctrl.sv
// Bang-bang CDR loop: window vote count, saturating PI filter, wrapping phase code, lock FSM; outputs land one cycle
// after each window close, no backpressure. Defining BBPD_CTRL_HOLD_EN adds a hold input that freezes the P and I updates.
module bbpd_loop_ctrl #(
  parameter int CODE_BITS  = 8,
  parameter int FRAC_BITS  = 4,
  parameter int INT_BITS   = 12,
  parameter int WIN_LOG2   = 4,
  parameter int KP         = 8,
  parameter int KI         = 1,
  parameter int LOCK_TH    = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  bbpd_loop_ctrl_if.slave bus
);
  localparam int ACC_BITS = CODE_BITS + FRAC_BITS;
  localparam int NET_BITS = WIN_LOG2 + 2;
  localparam int QC_BITS  = $clog2(LOCK_CNT + 1);
  localparam int NC_BITS  = $clog2(UNLOCK_CNT + 1);
  localparam int IMAX     = 2 ** (INT_BITS - 1) - 1;

  localparam logic signed [INT_BITS+1:0] SAT_HI = (INT_BITS + 2)'(IMAX);
  localparam logic signed [INT_BITS+1:0] SAT_LO = -SAT_HI;
  localparam logic signed [INT_BITS+1:0] KI_W   = (INT_BITS + 2)'(KI);
  localparam logic [ACC_BITS-1:0]        KP_W   = ACC_BITS'(KP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [ACC_BITS-1:0]         phase_acc_q, phase_acc_d;
  logic signed [INT_BITS-1:0]  integ_q, integ_d;
  logic signed [NET_BITS-1:0]  net_q, net_d;
  logic [WIN_LOG2-1:0]         win_cnt_q, win_cnt_d;
  logic [QC_BITS-1:0]          qcnt_q, qcnt_d;
  logic [NC_BITS-1:0]          ncnt_q, ncnt_d;
  logic                        code_valid_q, code_valid_d;
  logic                        locked_q, locked_d;

  logic                        hold_w;
  logic                        close;
  logic signed [NET_BITS-1:0]  vote;
  logic signed [NET_BITS-1:0]  net_sum;
  logic [NET_BITS-1:0]         net_abs;
  logic                        dir_pos, dir_neg, quiet;
  logic signed [INT_BITS+1:0]  integ_ext, integ_sum;
  logic signed [INT_BITS-1:0]  integ_sat, integ_new;
  logic [ACC_BITS-1:0]         integ_acc, p_term, acc_next;

`ifdef BBPD_CTRL_HOLD_EN
  assign hold_w = bus.hold;
`else
  assign hold_w = 1'b0;
`endif

  // Vote accumulation and PI arithmetic for the current cycle; only committed at window close.
  always_comb begin
    vote = '0;
    if (bus.up && !bus.dn) begin
      vote = NET_BITS'(1);
    end else if (bus.dn && !bus.up) begin
      vote = '1;
    end
    net_sum = net_q + vote;
    dir_neg = net_sum[NET_BITS-1];
    dir_pos = !dir_neg && (net_sum != '0);
    net_abs = dir_neg ? -net_sum : net_sum;
    quiet   = (net_abs <= NET_BITS'(LOCK_TH));
    close   = bus.en && (&win_cnt_q);

    integ_ext = {{2{integ_q[INT_BITS-1]}}, integ_q};
    if (dir_pos) begin
      integ_sum = integ_ext + KI_W;
    end else if (dir_neg) begin
      integ_sum = integ_ext - KI_W;
    end else begin
      integ_sum = integ_ext;
    end
    // Clamp symmetrically so the integrator never reaches the lone most-negative code.
    if (integ_sum > SAT_HI) begin
      integ_sat = SAT_HI[INT_BITS-1:0];
    end else if (integ_sum < SAT_LO) begin
      integ_sat = SAT_LO[INT_BITS-1:0];
    end else begin
      integ_sat = integ_sum[INT_BITS-1:0];
    end
    integ_new = hold_w ? integ_q : integ_sat;
    integ_acc = ACC_BITS'(integ_new);

    p_term = '0;
    if (!hold_w) begin
      if (dir_pos) begin
        p_term = KP_W;
      end else if (dir_neg) begin
        p_term = -KP_W;
      end
    end
    acc_next = phase_acc_q + p_term + integ_acc;
  end

  always_comb begin
    state_d      = state_q;
    phase_acc_d  = phase_acc_q;
    integ_d      = integ_q;
    net_d        = net_q;
    win_cnt_d    = win_cnt_q;
    qcnt_d       = qcnt_q;
    ncnt_d       = ncnt_q;
    code_valid_d = 1'b0;

    if (!bus.en) begin
      state_d   = IDLE;
      net_d     = '0;
      win_cnt_d = '0;
      qcnt_d    = '0;
      ncnt_d    = '0;
    end else begin
      win_cnt_d = win_cnt_q + 1'b1;
      net_d     = close ? '0 : net_sum;
      if (state_q == IDLE) begin
        state_d = ACQ;
      end
      if (close) begin
        integ_d      = integ_new;
        phase_acc_d  = acc_next;
        code_valid_d = 1'b1;
        if (state_q == LOCKED) begin
          if (quiet) begin
            ncnt_d = '0;
          end else if (ncnt_q == NC_BITS'(UNLOCK_CNT - 1)) begin
            state_d = ACQ;
            ncnt_d  = '0;
            qcnt_d  = '0;
          end else begin
            ncnt_d = ncnt_q + 1'b1;
          end
        end else begin
          if (!quiet) begin
            qcnt_d = '0;
          end else if (qcnt_q == QC_BITS'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            qcnt_d  = '0;
            ncnt_d  = '0;
          end else begin
            qcnt_d = qcnt_q + 1'b1;
          end
        end
      end
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_acc_q  <= '0;
      integ_q      <= '0;
      net_q        <= '0;
      win_cnt_q    <= '0;
      qcnt_q       <= '0;
      ncnt_q       <= '0;
      code_valid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_acc_q  <= phase_acc_d;
      integ_q      <= integ_d;
      net_q        <= net_d;
      win_cnt_q    <= win_cnt_d;
      qcnt_q       <= qcnt_d;
      ncnt_q       <= ncnt_d;
      code_valid_q <= code_valid_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.phase_code = phase_acc_q[ACC_BITS-1:FRAC_BITS];
  assign bus.code_valid = code_valid_q;
  assign bus.locked     = locked_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_bbpd_loop_ctrl.sv
// Directed bench for bbpd_loop_ctrl: hand-computed window table, then long wrap/saturation runs against a small
// reference of the PI update, enable gap, optional hold (BBPD_CTRL_HOLD_EN) and asynchronous reset mid-window.
module tb_bbpd_loop_ctrl;
  localparam int WIN = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bbpd_loop_ctrl_if bus ();
  bbpd_loop_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int n_up;
    int n_dn;
    int n_both;
    int code;
    int lck;
    int st;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   m_acc;
  int   m_integ;

  function automatic vec_t mk(int u, int d, int b, int c, int l, int s);
    vec_t v;
    v.n_up = u; v.n_dn = d; v.n_both = b; v.code = c; v.lck = l; v.st = s;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference PI update for one closed window.
  task automatic model_window(input int net, input bit hold_v);
    int dir;
    dir = (net > 0) ? 1 : ((net < 0) ? -1 : 0);
    if (!hold_v) begin
      m_integ = m_integ + dir;
      if (m_integ > 2047) m_integ = 2047;
      if (m_integ < -2047) m_integ = -2047;
    end
    m_acc = m_acc + (hold_v ? 0 : dir * 8) + m_integ;
    m_acc = ((m_acc % 4096) + 4096) % 4096;
  endtask

  // Drives one window starting #1 after a clock edge; ends #1 after the closing edge.
  task automatic run_window(input int n_up, input int n_dn, input int n_both, input string tag);
    for (int i = 0; i < WIN; i++) begin
      if (i < n_up) begin
        bus.up = 1'b1; bus.dn = 1'b0;
      end else if (i < n_up + n_dn) begin
        bus.up = 1'b0; bus.dn = 1'b1;
      end else if (i < n_up + n_dn + n_both) begin
        bus.up = 1'b1; bus.dn = 1'b1;
      end else begin
        bus.up = 1'b0; bus.dn = 1'b0;
      end
      @(posedge clk); #1;
      chk({tag, "/code_valid"}, int'(bus.code_valid), (i == WIN - 1) ? 1 : 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  prev;
    bit  wrap_seen;
    int  gap_code;

    // Initial state 0; each step below is integ/acc after the window, code = acc>>4.
    tbl.push_back(mk(16, 0, 0, 0, 0, 1));   // integ 1, acc 9
    tbl.push_back(mk(16, 0, 0, 1, 0, 1));   // 2, 19
    tbl.push_back(mk(16, 0, 0, 1, 0, 1));   // 3, 30
    tbl.push_back(mk(16, 0, 0, 2, 0, 1));   // 4, 42
    tbl.push_back(mk(0, 16, 0, 2, 0, 1));   // 3, 37
    tbl.push_back(mk(0, 16, 0, 1, 0, 1));   // 2, 31
    tbl.push_back(mk(0, 16, 0, 1, 0, 1));   // 1, 24
    tbl.push_back(mk(0, 16, 0, 1, 0, 1));   // 0, 16
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 16, 1, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 2));    // 8th quiet close -> locked
    tbl.push_back(mk(16, 0, 0, 1, 1, 2));   // 1, 25
    tbl.push_back(mk(16, 0, 0, 2, 1, 2));   // 2, 35
    tbl.push_back(mk(16, 0, 0, 2, 1, 2));   // 3, 46
    tbl.push_back(mk(0, 0, 0, 3, 1, 2));    // quiet resets the noisy count: 3, 49
    tbl.push_back(mk(16, 0, 0, 3, 1, 2));   // 4, 61
    tbl.push_back(mk(16, 0, 0, 4, 1, 2));   // 5, 74
    tbl.push_back(mk(16, 0, 0, 5, 1, 2));   // 6, 88
    tbl.push_back(mk(16, 0, 0, 6, 0, 1));   // 4th noisy -> ACQ: 7, 103
    tbl.push_back(mk(4, 0, 0, 7, 0, 1));    // net +4 quiet: 8, 119
    tbl.push_back(mk(0, 5, 0, 7, 0, 1));    // net -5 noisy: 7, 118
    tbl.push_back(mk(6, 6, 0, 7, 0, 1));    // net 0: 7, 125
    tbl.push_back(mk(4, 0, 0, 8, 0, 1));    // 8, 141
    tbl.push_back(mk(0, 4, 0, 8, 0, 1));    // 7, 140
    tbl.push_back(mk(4, 0, 0, 9, 0, 1));    // 8, 156
    tbl.push_back(mk(0, 4, 0, 9, 0, 1));    // 7, 155
    tbl.push_back(mk(4, 0, 0, 10, 0, 1));   // 8, 171
    tbl.push_back(mk(0, 4, 0, 10, 0, 1));   // 7, 170
    tbl.push_back(mk(4, 0, 0, 11, 1, 2));   // 8th quiet since the -5 window: 8, 186

    rst_n = 1'b0;
    bus.en = 1'b1; bus.up = 1'b1; bus.dn = 1'b0;
`ifdef BBPD_CTRL_HOLD_EN
    bus.hold = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst/phase_code", int'(bus.phase_code), 0);
      chk("rst/code_valid", int'(bus.code_valid), 0);
      chk("rst/locked", int'(bus.locked), 0);
      chk("rst/state", int'(bus.state), 0);
    end
    bus.en = 1'b0; bus.up = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle/state", int'(bus.state), 0);
      chk("idle/code_valid", int'(bus.code_valid), 0);
    end

    bus.en = 1'b1;
    foreach (tbl[k]) begin
      run_window(tbl[k].n_up, tbl[k].n_dn, tbl[k].n_both, $sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d/phase_code", k), int'(bus.phase_code), tbl[k].code);
      chk($sformatf("tbl%0d/locked", k), int'(bus.locked), tbl[k].lck);
      chk($sformatf("tbl%0d/state", k), int'(bus.state), tbl[k].st);
    end

    // Sustained dn: code falls through 0 and wraps to the top.
    m_acc = 186; m_integ = 8;
    wrap_seen = 1'b0;
    prev = m_acc >> 4;
    for (int w = 0; w < 40; w++) begin
      run_window(0, 16, 0, "dn_run");
      model_window(-16, 1'b0);
      chk("dn_run/phase_code", int'(bus.phase_code), m_acc >> 4);
      if (int'(bus.phase_code) > prev) wrap_seen = 1'b1;
      prev = int'(bus.phase_code);
    end
    chk("dn_run/wrap_0_to_255", int'(wrap_seen), 1);

    // Sustained up long enough to pin the integrator at +2047, wrapping 255->0 many times.
    wrap_seen = 1'b0;
    for (int w = 0; w < 2150; w++) begin
      run_window(16, 0, 0, "up_run");
      model_window(16, 1'b0);
      chk("up_run/phase_code", int'(bus.phase_code), m_acc >> 4);
      if (m_integ > -8 && int'(bus.phase_code) < prev) wrap_seen = 1'b1;
      prev = int'(bus.phase_code);
    end
    chk("up_run/wrap_255_to_0", int'(wrap_seen), 1);

    // Enable dropped at window cycle 7 for 5 cycles; partial votes must be discarded.
    gap_code = m_acc >> 4;
    bus.up = 1'b1; bus.dn = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("gap/pre_code_valid", int'(bus.code_valid), 0);
    end
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("gap/code_valid", int'(bus.code_valid), 0);
      chk("gap/phase_code", int'(bus.phase_code), gap_code);
      chk("gap/state", int'(bus.state), 0);
      chk("gap/locked", int'(bus.locked), 0);
    end
    bus.en = 1'b1;
    run_window(0, 4, 0, "reen");
    model_window(-4, 1'b0);
    chk("reen/phase_code", int'(bus.phase_code), m_acc >> 4);
    chk("reen/state", int'(bus.state), 1);

`ifdef BBPD_CTRL_HOLD_EN
    bus.hold = 1'b1;
    run_window(16, 0, 0, "hold_up");
    model_window(16, 1'b1);
    chk("hold_up/phase_code", int'(bus.phase_code), m_acc >> 4);
    run_window(0, 16, 0, "hold_dn");
    model_window(-16, 1'b1);
    chk("hold_dn/phase_code", int'(bus.phase_code), m_acc >> 4);
    run_window(0, 0, 0, "hold_none");
    model_window(0, 1'b1);
    chk("hold_none/phase_code", int'(bus.phase_code), m_acc >> 4);
    bus.hold = 1'b0;
`endif

    // Asynchronous reset in the middle of a window, then a clean restart.
    bus.up = 1'b1; bus.dn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("arst/phase_code", int'(bus.phase_code), 0);
    chk("arst/code_valid", int'(bus.code_valid), 0);
    chk("arst/locked", int'(bus.locked), 0);
    chk("arst/state", int'(bus.state), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run_window(16, 0, 0, "post_rst1");
    chk("post_rst1/phase_code", int'(bus.phase_code), 0);
    chk("post_rst1/state", int'(bus.state), 1);
    run_window(16, 0, 0, "post_rst2");
    chk("post_rst2/phase_code", int'(bus.phase_code), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
